// File: rtl/issue_unit.sv
// issue_unit: decode, rename and dispatch of one RV32I instruction per cycle
// into the reservation station or load/store buffer, with ROB allocation.
`timescale 1ns/1ps
module issue_unit #(
    parameter int ROB_W = 6,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             iq_valid,
    input  logic [31:0]      iq_inst,
    input  logic [31:0]      iq_pc,
    output logic             iq_pop,
    input  logic             rob_full,
    input  logic [ROB_W-1:0] rob_alloc_index,
    output logic [ROB_W-1:0] rob_q1_index,
    output logic [ROB_W-1:0] rob_q2_index,
    input  logic             rob_q1_ready,
    input  logic             rob_q2_ready,
    input  logic [31:0]      rob_q1_val,
    input  logic [31:0]      rob_q2_val,
    input  logic             rs_full,
    input  logic             lsb_full,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_rob_index_out,
    input  logic [31:0]      alu_res,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    input  logic [ROB_W-1:0] commit_rob_index,
    input  logic [31:0]      commit_val,
    input  logic             flush,
    output logic             issue_valid,
    output logic             lsb_issue_valid,
    output logic             rob_issue_valid,
    output logic [5:0]       issue_opcode,
    output logic [31:0]      issue_val1,
    output logic [31:0]      issue_val2,
    output logic [ROB_W-1:0] issue_dep1,
    output logic [ROB_W-1:0] issue_dep2,
    output logic             issue_has_dep1,
    output logic             issue_has_dep2,
    output logic [ROB_W-1:0] issue_rob_index,
    output logic [31:0]      issue_imm,
    output logic [31:0]      issue_pc,
    output logic [4:0]       issue_rd
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Architectural state: values, pending-writer flags and pending-writer tags.
    logic [31:0]      regfile_r [NREG];
    logic [NREG-1:0]  reg_busy_r;
    logic [ROB_W-1:0] reg_tag_r [NREG];

    logic [6:0]  opc_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [31:0] i_imm_s, s_imm_s, b_imm_s, u_imm_s, j_imm_s;
    logic [5:0]  op_s;
    logic [31:0] imm_s;

    assign opc_s   = iq_inst[6:0];
    assign rd_s    = iq_inst[11:7];
    assign f3_s    = iq_inst[14:12];
    assign rs1_s   = iq_inst[19:15];
    assign rs2_s   = iq_inst[24:20];
    assign f7_s    = iq_inst[31:25];
    assign i_imm_s = {{20{iq_inst[31]}}, iq_inst[31:20]};
    assign s_imm_s = {{20{iq_inst[31]}}, iq_inst[31:25], iq_inst[11:7]};
    assign b_imm_s = {{19{iq_inst[31]}}, iq_inst[31], iq_inst[7], iq_inst[30:25], iq_inst[11:8], 1'b0};
    assign u_imm_s = {iq_inst[31:12], 12'd0};
    assign j_imm_s = {{11{iq_inst[31]}}, iq_inst[31], iq_inst[19:12], iq_inst[20], iq_inst[30:21], 1'b0};

    // Decode the head instruction into the internal opcode number and immediate.
    always_comb begin
        op_s  = 6'd0;
        imm_s = 32'd0;
        case (opc_s)
            OPC_LUI:   begin op_s = 6'd1; imm_s = u_imm_s; end
            OPC_AUIPC: begin op_s = 6'd2; imm_s = u_imm_s; end
            OPC_JAL:   begin op_s = 6'd3; imm_s = j_imm_s; end
            OPC_JALR: begin
                imm_s = i_imm_s;
                if (f3_s == 3'b000) op_s = 6'd4;
                else                op_s = 6'd0;
            end
            OPC_BRANCH: begin
                imm_s = b_imm_s;
                case (f3_s)
                    3'b000:  op_s = 6'd5;
                    3'b001:  op_s = 6'd6;
                    3'b100:  op_s = 6'd7;
                    3'b101:  op_s = 6'd8;
                    3'b110:  op_s = 6'd9;
                    3'b111:  op_s = 6'd10;
                    default: op_s = 6'd0;
                endcase
            end
            OPC_LOAD: begin
                imm_s = i_imm_s;
                case (f3_s)
                    3'b000:  op_s = 6'd11;
                    3'b001:  op_s = 6'd12;
                    3'b010:  op_s = 6'd13;
                    3'b100:  op_s = 6'd14;
                    3'b101:  op_s = 6'd15;
                    default: op_s = 6'd0;
                endcase
            end
            OPC_STORE: begin
                imm_s = s_imm_s;
                case (f3_s)
                    3'b000:  op_s = 6'd16;
                    3'b001:  op_s = 6'd17;
                    3'b010:  op_s = 6'd18;
                    default: op_s = 6'd0;
                endcase
            end
            OPC_OPIMM: begin
                imm_s = i_imm_s;
                case (f3_s)
                    3'b000:  op_s = 6'd19;
                    3'b010:  op_s = 6'd20;
                    3'b011:  op_s = 6'd21;
                    3'b100:  op_s = 6'd22;
                    3'b110:  op_s = 6'd23;
                    3'b111:  op_s = 6'd24;
                    3'b001: begin
                        imm_s = {27'd0, iq_inst[24:20]};
                        if (f7_s == 7'b0000000) op_s = 6'd25;
                        else                    op_s = 6'd0;
                    end
                    3'b101: begin
                        imm_s = {27'd0, iq_inst[24:20]};
                        if (f7_s == 7'b0000000)      op_s = 6'd26;
                        else if (f7_s == 7'b0100000) op_s = 6'd27;
                        else                         op_s = 6'd0;
                    end
                    default: op_s = 6'd0;
                endcase
            end
            OPC_OP: begin
                imm_s = 32'd0;
                case ({f7_s, f3_s})
                    10'b0000000_000: op_s = 6'd28;
                    10'b0100000_000: op_s = 6'd29;
                    10'b0000000_001: op_s = 6'd30;
                    10'b0000000_010: op_s = 6'd31;
                    10'b0000000_011: op_s = 6'd32;
                    10'b0000000_100: op_s = 6'd33;
                    10'b0000000_101: op_s = 6'd34;
                    10'b0100000_101: op_s = 6'd35;
                    10'b0000000_110: op_s = 6'd36;
                    10'b0000000_111: op_s = 6'd37;
                    default:         op_s = 6'd0;
                endcase
            end
            default: begin
                op_s  = 6'd0;
                imm_s = 32'd0;
            end
        endcase
    end

    logic legal_s, mem_s, branch_s, store_s, uses_rs1_s, uses_rs2_s;
    logic go_s, issue_s, rename_s, commit_clear_s;

    assign legal_s    = (op_s != 6'd0);
    assign branch_s   = (op_s >= 6'd5)  && (op_s <= 6'd10);
    assign store_s    = (op_s >= 6'd16) && (op_s <= 6'd18);
    assign mem_s      = (op_s >= 6'd11) && (op_s <= 6'd18);
    assign uses_rs1_s = (op_s >= 6'd4);
    assign uses_rs2_s = branch_s || store_s || (op_s >= 6'd28);

    // Reset also blocks the pop so the queue never loses an instruction into a reset cycle.
    assign go_s     = ~rst & rdy & iq_valid & ~flush & ~rob_full & (mem_s ? ~lsb_full : ~rs_full);
    assign issue_s  = go_s & legal_s;
    assign rename_s = issue_s & ~branch_s & ~store_s & (rd_s != 5'd0);
    assign iq_pop   = go_s;

    assign commit_clear_s = commit_valid && (commit_rd != 5'd0) &&
                            (reg_tag_r[commit_rd] == commit_rob_index);

    assign rob_q1_index = reg_tag_r[rs1_s];
    assign rob_q2_index = reg_tag_r[rs2_s];

    // Returns {has_dep, dep, val} following the value/bypass/dependency priority.
    function automatic logic [ROB_W+32:0] resolve_operand(
        input logic             used,
        input logic [4:0]       rs,
        input logic             busy,
        input logic [ROB_W-1:0] tag,
        input logic [31:0]      rf_val,
        input logic             commit_fwd,
        input logic [31:0]      fwd_val,
        input logic             alu_hit,
        input logic [31:0]      alu_val,
        input logic             q_ready,
        input logic [31:0]      q_val
    );
        logic [ROB_W+32:0] res;
        if (!used || rs == 5'd0) res = {1'b0, {ROB_W{1'b0}}, 32'd0};
        else if (!busy)          res = {1'b0, {ROB_W{1'b0}}, (commit_fwd ? fwd_val : rf_val)};
        else if (alu_hit)        res = {1'b0, {ROB_W{1'b0}}, alu_val};
        else if (q_ready)        res = {1'b0, {ROB_W{1'b0}}, q_val};
        else                     res = {1'b1, tag, 32'd0};
        return res;
    endfunction

    logic             has1_s, has2_s;
    logic [ROB_W-1:0] dep1_s, dep2_s;
    logic [31:0]      val1_s, val2_s;

    assign {has1_s, dep1_s, val1_s} = resolve_operand(
        uses_rs1_s, rs1_s, reg_busy_r[rs1_s], reg_tag_r[rs1_s], regfile_r[rs1_s],
        commit_valid && (commit_rd == rs1_s), commit_val,
        alu_valid && (alu_rob_index_out == reg_tag_r[rs1_s]), alu_res,
        rob_q1_ready, rob_q1_val);

    assign {has2_s, dep2_s, val2_s} = resolve_operand(
        uses_rs2_s, rs2_s, reg_busy_r[rs2_s], reg_tag_r[rs2_s], regfile_r[rs2_s],
        commit_valid && (commit_rd == rs2_s), commit_val,
        alu_valid && (alu_rob_index_out == reg_tag_r[rs2_s]), alu_res,
        rob_q2_ready, rob_q2_val);

    // Register the capture strobes every enabled cycle and the payload on each pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid     <= 1'b0;
            lsb_issue_valid <= 1'b0;
            rob_issue_valid <= 1'b0;
            issue_opcode    <= 6'd0;
            issue_val1      <= 32'd0;
            issue_val2      <= 32'd0;
            issue_dep1      <= {ROB_W{1'b0}};
            issue_dep2      <= {ROB_W{1'b0}};
            issue_has_dep1  <= 1'b0;
            issue_has_dep2  <= 1'b0;
            issue_rob_index <= {ROB_W{1'b0}};
            issue_imm       <= 32'd0;
            issue_pc        <= 32'd0;
            issue_rd        <= 5'd0;
        end else if (rdy) begin
            rob_issue_valid <= issue_s;
            issue_valid     <= issue_s & ~mem_s;
            lsb_issue_valid <= issue_s & mem_s;
            if (go_s) begin
                issue_opcode    <= op_s;
                issue_val1      <= val1_s;
                issue_val2      <= val2_s;
                issue_dep1      <= dep1_s;
                issue_dep2      <= dep2_s;
                issue_has_dep1  <= has1_s;
                issue_has_dep2  <= has2_s;
                issue_rob_index <= rob_alloc_index;
                issue_imm       <= imm_s;
                issue_pc        <= iq_pc;
                issue_rd        <= rd_s;
            end
        end
    end

    // Committed results land in the register file, flush or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regfile_r[i] <= 32'd0;
        end else if (rdy && commit_valid && commit_rd != 5'd0) begin
            regfile_r[commit_rd] <= commit_val;
        end
    end

    // Track the youngest in-flight writer of each register; a rename beats a same-cycle commit clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_busy_r <= {NREG{1'b0}};
            for (int i = 0; i < NREG; i++) reg_tag_r[i] <= {ROB_W{1'b0}};
        end else if (rdy) begin
            if (flush) begin
                reg_busy_r <= {NREG{1'b0}};
            end else if (commit_clear_s) begin
                reg_busy_r[commit_rd] <= 1'b0;
            end
            if (rename_s) begin
                reg_busy_r[rd_s] <= 1'b1;
                reg_tag_r[rd_s]  <= rob_alloc_index;
            end
        end
    end
endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed scenarios plus randomized traffic
// compared against an instruction-level model of rename/dispatch.
`timescale 1ns/1ps
module tb_issue_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, iq_valid, iq_pop, rob_full;
    logic [31:0] iq_inst, iq_pc;
    logic [5:0]  rob_alloc_index, rob_q1_index, rob_q2_index;
    logic        rob_q1_ready, rob_q2_ready;
    logic [31:0] rob_q1_val, rob_q2_val;
    logic        rs_full, lsb_full, alu_valid, commit_valid, flush;
    logic [5:0]  alu_rob_index_out, commit_rob_index;
    logic [31:0] alu_res, commit_val;
    logic [4:0]  commit_rd;
    logic        issue_valid, lsb_issue_valid, rob_issue_valid;
    logic [5:0]  issue_opcode, issue_dep1, issue_dep2, issue_rob_index;
    logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
    logic        issue_has_dep1, issue_has_dep2;
    logic [4:0]  issue_rd;

    issue_unit #(.ROB_W(6), .NREG(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_pop(iq_pop),
        .rob_full(rob_full), .rob_alloc_index(rob_alloc_index),
        .rob_q1_index(rob_q1_index), .rob_q2_index(rob_q2_index),
        .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
        .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
        .rs_full(rs_full), .lsb_full(lsb_full),
        .alu_valid(alu_valid), .alu_rob_index_out(alu_rob_index_out), .alu_res(alu_res),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rob_index(commit_rob_index), .commit_val(commit_val),
        .flush(flush),
        .issue_valid(issue_valid), .lsb_issue_valid(lsb_issue_valid),
        .rob_issue_valid(rob_issue_valid), .issue_opcode(issue_opcode),
        .issue_val1(issue_val1), .issue_val2(issue_val2),
        .issue_dep1(issue_dep1), .issue_dep2(issue_dep2),
        .issue_has_dep1(issue_has_dep1), .issue_has_dep2(issue_has_dep2),
        .issue_rob_index(issue_rob_index), .issue_imm(issue_imm),
        .issue_pc(issue_pc), .issue_rd(issue_rd)
    );

    int n_checks = 0;
    int n_err    = 0;

    // MATCH values of the RV32I instructions, indexed by the internal opcode number.
    localparam logic [31:0] MATCH_T [38] = '{
        32'h00000000, 32'h00000037, 32'h00000017, 32'h0000006f, 32'h00000067,
        32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063, 32'h00006063, 32'h00007063,
        32'h00000003, 32'h00001003, 32'h00002003, 32'h00004003, 32'h00005003,
        32'h00000023, 32'h00001023, 32'h00002023,
        32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013, 32'h00006013, 32'h00007013,
        32'h00001013, 32'h00005013, 32'h40005013,
        32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033,
        32'h00004033, 32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033
    };

    function automatic logic [31:0] mask_of(input int k);
        if (k <= 3)       return 32'h0000007f;
        else if (k >= 25) return 32'hfe00707f;
        else              return 32'h0000707f;
    endfunction

    function automatic logic [5:0] ref_decode(input logic [31:0] w);
        for (int k = 1; k <= 37; k++)
            if ((w & mask_of(k)) == MATCH_T[k]) return 6'(k);
        return 6'd0;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [5:0] op, input logic [31:0] w);
        logic signed [31:0] sw;
        sw = w;
        if (op == 6'd1 || op == 6'd2) return w & 32'hfffff000;
        if (op == 6'd3) return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        if (op >= 6'd5 && op <= 6'd10) return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        if (op >= 6'd16 && op <= 6'd18) return 32'((sw >>> 25) << 5) | {27'd0, w[11:7]};
        if (op >= 6'd25 && op <= 6'd27) return {27'd0, w[24:20]};
        if (op >= 6'd28) return 32'd0;
        return 32'(sw >>> 20);
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int k;
        if ($urandom_range(0, 9) == 0) return $urandom;
        k = $urandom_range(1, 37);
        w = MATCH_T[k] | ($urandom & ~mask_of(k));
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // Model state and the registered outputs it predicts.
    logic [31:0] m_rf [32];
    logic        m_busy [32];
    logic [5:0]  m_tag [32];
    logic        e_iv, e_lv, e_rv, e_h1, e_h2, e_pay;
    logic [5:0]  e_op, e_d1, e_d2, e_ri;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [4:0]  e_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resolve(input logic used, input logic [4:0] rs, input logic qr,
                           input logic [31:0] qv, output logic [31:0] v,
                           output logic hd, output logic [5:0] d);
        v = 32'd0; hd = 1'b0; d = 6'd0;
        if (used && rs != 5'd0) begin
            if (!m_busy[rs]) v = (commit_valid && commit_rd == rs) ? commit_val : m_rf[rs];
            else if (alu_valid && alu_rob_index_out == m_tag[rs]) v = alu_res;
            else if (qr) v = qv;
            else begin hd = 1'b1; d = m_tag[rs]; end
        end
    endtask

    // One clock: inputs already driven at a negedge; ends at the next negedge after comparing.
    task automatic step();
        logic [5:0]  op;
        logic        mem, go, u1, u2, wr;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2;
        logic        h1, h2;
        logic [5:0]  d1, d2;
        #1;
        op  = ref_decode(iq_inst);
        rs1 = iq_inst[19:15]; rs2 = iq_inst[24:20]; rd = iq_inst[11:7];
        mem = (op >= 6'd11 && op <= 6'd18);
        go  = !rst && rdy && iq_valid && !flush && !rob_full && (mem ? !lsb_full : !rs_full);
        u1  = !(op >= 6'd1 && op <= 6'd3);
        u2  = (op >= 6'd5 && op <= 6'd10) || (op >= 6'd16 && op <= 6'd18) || (op >= 6'd28);
        wr  = !(op >= 6'd5 && op <= 6'd10) && !(op >= 6'd16 && op <= 6'd18);
        chk("iq_pop", 32'(iq_pop), 32'(go));
        if (!rst) begin
            chk("rob_q1_index", 32'(rob_q1_index), 32'(m_tag[rs1]));
            chk("rob_q2_index", 32'(rob_q2_index), 32'(m_tag[rs2]));
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_rf[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 6'd0; end
            {e_iv, e_lv, e_rv, e_h1, e_h2} = 5'd0;
            {e_op, e_d1, e_d2, e_ri} = 24'd0;
            {e_v1, e_v2, e_imm, e_pc} = 128'd0;
            e_rd = 5'd0; e_pay = 1'b1;
        end else if (rdy) begin
            resolve(u1, rs1, rob_q1_ready, rob_q1_val, v1, h1, d1);
            resolve(u2, rs2, rob_q2_ready, rob_q2_val, v2, h2, d2);
            e_rv = go && (op != 6'd0);
            e_iv = e_rv && !mem;
            e_lv = e_rv && mem;
            e_pay = e_rv;
            if (e_rv) begin
                e_op = op; e_v1 = v1; e_v2 = v2; e_h1 = h1; e_h2 = h2; e_d1 = d1; e_d2 = d2;
                e_ri = rob_alloc_index; e_imm = ref_imm(op, iq_inst); e_pc = iq_pc; e_rd = rd;
            end
            if (commit_valid && commit_rd != 5'd0) begin
                m_rf[commit_rd] = commit_val;
                if (m_tag[commit_rd] == commit_rob_index) m_busy[commit_rd] = 1'b0;
            end
            if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            if (e_rv && wr && rd != 5'd0) begin m_busy[rd] = 1'b1; m_tag[rd] = rob_alloc_index; end
        end
        @(negedge clk);
        chk("issue_valid", 32'(issue_valid), 32'(e_iv));
        chk("lsb_issue_valid", 32'(lsb_issue_valid), 32'(e_lv));
        chk("rob_issue_valid", 32'(rob_issue_valid), 32'(e_rv));
        if (e_pay) begin
            chk("issue_opcode", 32'(issue_opcode), 32'(e_op));
            chk("issue_val1", issue_val1, e_v1);
            chk("issue_val2", issue_val2, e_v2);
            chk("issue_has_dep1", 32'(issue_has_dep1), 32'(e_h1));
            chk("issue_has_dep2", 32'(issue_has_dep2), 32'(e_h2));
            if (e_h1) chk("issue_dep1", 32'(issue_dep1), 32'(e_d1));
            if (e_h2) chk("issue_dep2", 32'(issue_dep2), 32'(e_d2));
            chk("issue_rob_index", 32'(issue_rob_index), 32'(e_ri));
            chk("issue_imm", issue_imm, e_imm);
            chk("issue_pc", issue_pc, e_pc);
            chk("issue_rd", 32'(issue_rd), 32'(e_rd));
        end
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; iq_valid = 1'b0; iq_inst = 32'd0; iq_pc = 32'd0;
        rob_full = 1'b0; rob_alloc_index = 6'd0;
        rob_q1_ready = 1'b0; rob_q2_ready = 1'b0; rob_q1_val = 32'd0; rob_q2_val = 32'd0;
        rs_full = 1'b0; lsb_full = 1'b0;
        alu_valid = 1'b0; alu_rob_index_out = 6'd0; alu_res = 32'd0;
        commit_valid = 1'b0; commit_rd = 5'd0; commit_rob_index = 6'd0; commit_val = 32'd0;
        flush = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w, input logic [31:0] pc, input logic [5:0] tag);
        iq_valid = 1'b1; iq_inst = w; iq_pc = pc; rob_alloc_index = tag;
    endtask

    task automatic drive_random();
        logic [4:0] r;
        rst  = ($urandom_range(0, 299) == 0);
        rdy  = ($urandom_range(0, 9) != 0);
        iq_valid = ($urandom_range(0, 4) != 0);
        iq_inst  = gen_inst();
        iq_pc    = $urandom;
        rob_full = ($urandom_range(0, 9) == 0);
        rob_alloc_index = 6'($urandom);
        rob_q1_ready = ($urandom_range(0, 2) == 0); rob_q1_val = $urandom;
        rob_q2_ready = ($urandom_range(0, 2) == 0); rob_q2_val = $urandom;
        rs_full  = ($urandom_range(0, 5) == 0);
        lsb_full = ($urandom_range(0, 5) == 0);
        r = $urandom_range(0, 1) ? iq_inst[19:15] : iq_inst[24:20];
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_rob_index_out = $urandom_range(0, 1) ? m_tag[r] : 6'($urandom);
        alu_res = $urandom;
        commit_valid = ($urandom_range(0, 4) < 2);
        commit_rd = 5'($urandom_range(0, 3));
        commit_rob_index = $urandom_range(0, 1) ? m_tag[commit_rd] : 6'($urandom);
        commit_val = $urandom;
        flush = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        step(); step();
        chk("reset_rob_issue_valid", 32'(rob_issue_valid), 32'd0);
        chk("reset_issue_opcode", 32'(issue_opcode), 32'd0);
        rst = 1'b0;

        // ADDI x1,x0,5 with ROB tag 3
        issue(32'h00500093, 32'h0, 6'd3);
        step();
        chk("addi_issue_valid", 32'(issue_valid), 32'd1);
        chk("addi_opcode", 32'(issue_opcode), 32'd19);
        chk("addi_imm", issue_imm, 32'd5);
        chk("addi_rob_index", 32'(issue_rob_index), 32'd3);
        chk("addi_val1", issue_val1, 32'd0);

        // ADD x2,x1,x1 waits on tag 3
        issue(32'h00108133, 32'h4, 6'd4);
        #1 chk("add_q1_index", 32'(rob_q1_index), 32'd3);
        step();
        chk("add_opcode", 32'(issue_opcode), 32'd28);
        chk("add_has_dep1", 32'(issue_has_dep1), 32'd1);
        chk("add_has_dep2", 32'(issue_has_dep2), 32'd1);
        chk("add_dep1", 32'(issue_dep1), 32'd3);
        chk("add_dep2", 32'(issue_dep2), 32'd3);

        // Same ADD with tag 3 broadcast by the ALU this cycle
        issue(32'h00108133, 32'h8, 6'd5);
        alu_valid = 1'b1; alu_rob_index_out = 6'd3; alu_res = 32'd5;
        step();
        chk("bypass_val1", issue_val1, 32'd5);
        chk("bypass_val2", issue_val2, 32'd5);
        chk("bypass_has_dep1", 32'(issue_has_dep1), 32'd0);
        alu_valid = 1'b0;

        // RS full stalls the ADD
        rs_full = 1'b1;
        issue(32'h00108133, 32'hc, 6'd6);
        #1 chk("rsfull_pop", 32'(iq_pop), 32'd0);
        step();
        chk("rsfull_rob_issue_valid", 32'(rob_issue_valid), 32'd0);

        // SW x1,0(x0) still goes to the LSB
        issue(32'h00102023, 32'hc, 6'd6);
        step();
        chk("sw_lsb_issue_valid", 32'(lsb_issue_valid), 32'd1);
        chk("sw_issue_valid", 32'(issue_valid), 32'd0);
        chk("sw_opcode", 32'(issue_opcode), 32'd18);
        rs_full = 1'b0;

        // Commit x1 = 7 from tag 3, then read it
        iq_valid = 1'b0;
        commit_valid = 1'b1; commit_rd = 5'd1; commit_rob_index = 6'd3; commit_val = 32'd7;
        step();
        commit_valid = 1'b0;
        issue(32'h00008193, 32'h10, 6'd7);
        step();
        chk("commit_read_val1", issue_val1, 32'd7);
        chk("commit_read_has_dep1", 32'(issue_has_dep1), 32'd0);

        // Rename x1 to tag 9, stale commit from tag 2 keeps it busy
        issue(32'h00500093, 32'h14, 6'd9);
        step();
        iq_valid = 1'b0;
        commit_valid = 1'b1; commit_rd = 5'd1; commit_rob_index = 6'd2; commit_val = 32'd9;
        step();
        commit_valid = 1'b0;
        issue(32'h00108133, 32'h18, 6'd10);
        step();
        chk("stale_has_dep1", 32'(issue_has_dep1), 32'd1);
        chk("stale_dep1", 32'(issue_dep1), 32'd9);

        // Flush with an ADD pending
        issue(32'h00108133, 32'h1c, 6'd11);
        flush = 1'b1;
        #1 chk("flush_pop", 32'(iq_pop), 32'd0);
        step();
        chk("flush_issue_valid", 32'(issue_valid), 32'd0);
        chk("flush_rob_issue_valid", 32'(rob_issue_valid), 32'd0);
        flush = 1'b0;
        issue(32'h00008193, 32'h20, 6'd12);
        step();
        chk("postflush_val1", issue_val1, 32'd9);
        chk("postflush_has_dep1", 32'(issue_has_dep1), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- Decode/rename/dispatch stage directly upstream of the reservation station (RS) and load/store buffer (LSB).
- Pops one RV32I instruction per cycle from the instruction queue and decodes it to a 6-bit opcode plus immediate.
- Resolves both source operands to a value or a ROB-tag dependency, using an internal register file, a register status table, ROB lookup and ALU-broadcast bypass.
- Allocates the ROB entry and drives the registered issue bus into RS or LSB.

Parameters:
ROB_W, 6, ROB index width (matches RS dep/rob_index width)
NREG, 32, architectural registers

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; all state holds when low
iq_valid  in  1  instruction queue has an entry
iq_inst  in  32  instruction word
iq_pc  in  32  instruction PC
iq_pop  out  1  combinational; head consumed this cycle
rob_full  in  1  ROB cannot accept
rob_alloc_index  in  6  ROB tail index for this cycle's instruction
rob_q1_index, rob_q2_index  out  6  combinational query tags (reg_tag[rs1], reg_tag[rs2])
rob_q1_ready, rob_q2_ready  in  1  queried entry has its result
rob_q1_val, rob_q2_val  in  32  queried entry's result
rs_full  in  1  from RS (asserts with one slot spare)
lsb_full  in  1  from LSB (same one-slot-spare rule)
alu_valid  in  1  ALU result broadcast
alu_rob_index_out  in  6  broadcast tag
alu_res  in  32  broadcast value
commit_valid  in  1  ROB commits a register write
commit_rd  in  5  commit destination
commit_rob_index  in  6  committing entry tag
commit_val  in  32  commit value
flush  in  1  misprediction flush
issue_valid  out  1  registered; RS capture strobe
lsb_issue_valid  out  1  registered; LSB capture strobe
rob_issue_valid  out  1  registered; ROB capture strobe
issue_opcode  out  6  shared payload bus to RS, LSB and ROB (registered)
issue_val1, issue_val2  out  32  shared payload
issue_dep1, issue_dep2  out  6  shared payload
issue_has_dep1, issue_has_dep2  out  1  shared payload
issue_rob_index  out  6  shared payload
issue_imm  out  32  shared payload
issue_pc  out  32  shared payload
issue_rd  out  5  shared payload

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On reset:
  - all outputs 0;
  - register file, reg_busy[31:0] and reg_tag cleared.
- Opcode encoding (0 = none/illegal):
  - LUI 1, AUIPC 2, JAL 3, JALR 4;
  - BEQ,BNE,BLT,BGE,BLTU,BGEU 5-10;
  - LB,LH,LW,LBU,LHU 11-15;
  - SB,SH,SW 16-18;
  - ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI 19-27;
  - ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND 28-37.
- Immediates are sign-extended per the I/S/B/U/J formats. Shift-immediates give imm = shamt.
- Issue condition (combinational):
  - go = rdy & iq_valid & ~flush & ~rob_full & (mem ? ~lsb_full : ~rs_full), where mem = opcodes 11-18.
  - iq_pop = go.
  - An illegal opcode still pops, issues nothing and renames nothing.
- Latency: payload and strobes are registered, so they appear one cycle after go.
  - On the go cycle: rob_issue_valid <= 1; issue_valid <= ~mem; lsb_issue_valid <= mem.
  - On any non-go cycle all three strobes <= 0. Payload may hold its stale value.
- Operand resolution for rs (independently for rs1 and rs2), in priority order:
  - rs unused, or rs = x0: val = 0, has_dep = 0.
    - rs1 is used by all opcodes except 1-3.
    - rs2 is used by 5-10, 16-18 and 28-37.
  - ~reg_busy[rs]: val = regfile[rs], has_dep = 0. Same-cycle commit to rs is forwarded.
  - busy and alu_valid & alu_rob_index_out == reg_tag[rs]: val = alu_res, has_dep = 0.
  - busy and rob_qN_ready: val = rob_qN_val, has_dep = 0.
  - otherwise: dep = reg_tag[rs], has_dep = 1, val = 0.
- Rename: on go with rd != 0 and opcode not in 5-10 or 16-18:
  - reg_busy[rd] <= 1;
  - reg_tag[rd] <= rob_alloc_index.
- Commit: on commit_valid with commit_rd != 0:
  - regfile[commit_rd] <= commit_val, always;
  - reg_busy[commit_rd] <= 0 only if reg_tag == commit_rob_index;
  - a rename of the same rd in the same cycle overrides the clear.
- Flush: all reg_busy <= 0 and all strobes <= 0.
  - A commit in the flush cycle is still written to the register file.
  - The register file is otherwise preserved.
- rdy low: no pop, no state change, outputs hold.

Test Plan:
- Reset, rob_alloc_index=3, ADDI x1,x0,5 (0x00500093, pc 0) -> iq_pop=1; next cycle issue_valid=1, opcode 19, val1=0, has_dep1=0, imm=5, rob_index=3; x1 busy with tag 3.
- Then ADD x2,x1,x1 (0x00108133), rob_q ready=0 -> has_dep1=has_dep2=1, dep1=dep2=3, opcode 28.
- Same ADD with alu_valid=1, alu_rob_index_out=3, alu_res=5 in the issue cycle -> val1=val2=5, no deps.
- rs_full=1: ADD gives iq_pop=0 and no strobes; SW x1,0(x0) with lsb_full=0 issues with lsb_issue_valid=1, issue_valid=0, opcode 18.
- commit_rd=1, tag 3, val 7 -> x1 free, later read gives 7; commit with stale tag 2 leaves x1 busy.
- flush with an ADD pending -> iq_pop=0, strobes 0 next cycle; a following read of x1 returns the register-file value with no dependency.
